// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit framing engine: one bit per CLK, frame = start, WIDTH data bits
// LSB first, optional parity bit taken from the parity calculator, stop.
module uart_tx_frame_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] P_DATA,
   input  logic             DATA_VALID,
   input  logic             PAR_EN,
   input  logic             PARITY,
   output logic             TX_OUT,
   output logic             BUSY
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_PAR   = 3'd3;
   localparam logic [2:0] ST_STOP  = 3'd4;

   logic [2:0]       state_q,  state_d;
   logic [WIDTH-1:0] shift_q,  shift_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             par_en_q, par_en_d;
   logic             tx_q,     tx_d;
   logic             busy_q,   busy_d;

   // State and registered outputs; RST abandons any frame in flight
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         par_en_q <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         par_en_q <= par_en_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
      end
   end

   // Next state plus the line/busy values for the state being entered
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      par_en_d = par_en_q;
      tx_d     = tx_q;
      busy_d   = busy_q;

      case (state_q)
         ST_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (DATA_VALID) begin
               shift_d  = P_DATA;
               par_en_d = PAR_EN;
               cnt_d    = '0;
               state_d  = ST_START;
               tx_d     = 1'b0;
               busy_d   = 1'b1;
            end
         end
         ST_START: begin
            state_d = ST_DATA;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[WIDTH-1:1]};
            cnt_d   = '0;
            busy_d  = 1'b1;
         end
         ST_DATA: begin
            busy_d = 1'b1;
            if (cnt_q == CNT_LAST) begin
               if (par_en_q) begin
                  state_d = ST_PAR;
                  tx_d    = PARITY;
               end else begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end
            end else begin
               tx_d    = shift_q[0];
               shift_d = {1'b0, shift_q[WIDTH-1:1]};
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         ST_PAR: begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
            busy_d  = 1'b1;
         end
         ST_STOP: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign TX_OUT = tx_q;
   assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed self-checking bench for uart_tx_frame_ctrl (WIDTH=8).
module tb_uart_tx_frame_ctrl;

   localparam int unsigned WIDTH = 8;

   logic             CLK;
   logic             RST;
   logic [WIDTH-1:0] P_DATA;
   logic             DATA_VALID;
   logic             PAR_EN;
   logic             PARITY;
   logic             TX_OUT;
   logic             BUSY;

   int checks   = 0;
   int failures = 0;

   uart_tx_frame_ctrl #(.WIDTH(WIDTH)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_EN     (PAR_EN),
      .PARITY     (PARITY),
      .TX_OUT     (TX_OUT),
      .BUSY       (BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         check($sformatf("%s_tx%0d", tag, i), TX_OUT, 1'b1);
         check($sformatf("%s_busy%0d", tag, i), BUSY, 1'b0);
         @(negedge CLK);
      end
   endtask

   // Presents a word at a negedge; returns at the negedge of the start-bit cycle
   task automatic send(input logic [WIDTH-1:0] data, input logic pe);
      P_DATA     = data;
      PAR_EN     = pe;
      DATA_VALID = 1'b1;
      @(negedge CLK);
   endtask

   // Checks a whole frame from the start-bit cycle, then the first idle cycle.
   // inj_a/inj_b: frame cycle indices in which a rejected word (00) is offered.
   task automatic expect_frame(input string tag, input logic [WIDTH-1:0] data,
                               input logic pe, input logic par,
                               input int inj_a, input int inj_b, input logic hold);
      logic [WIDTH-1:0] d;
      logic             exp_bit;
      int               len;
      d   = data;
      len = int'(WIDTH) + 2 + (pe ? 1 : 0);
      for (int i = 0; i < len; i++) begin
         if (i == 0)                          exp_bit = 1'b0;
         else if (i <= int'(WIDTH))           exp_bit = d[i-1];
         else if (pe && i == int'(WIDTH) + 1) exp_bit = par;
         else                                 exp_bit = 1'b1;
         check($sformatf("%s_tx%0d", tag, i), TX_OUT, exp_bit);
         check($sformatf("%s_busy%0d", tag, i), BUSY, 1'b1);
         if (i == 0 && !hold) begin
            P_DATA = ~data;
            PAR_EN = ~pe;
         end
         if (i == inj_a || i == inj_b) begin
            DATA_VALID = 1'b1;
            P_DATA     = '0;
         end else if (!hold) begin
            DATA_VALID = 1'b0;
         end
         @(negedge CLK);
      end
      check($sformatf("%s_end_tx", tag), TX_OUT, 1'b1);
      check($sformatf("%s_end_busy", tag), BUSY, 1'b0);
   endtask

   initial begin
      RST        = 1'b1;
      DATA_VALID = 1'b1;
      P_DATA     = 8'hA5;
      PAR_EN     = 1'b0;
      PARITY     = 1'b0;

      // Reset held 3 cycles with DATA_VALID asserted
      @(negedge CLK);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_tx%0d", i), TX_OUT, 1'b1);
         check($sformatf("rst_busy%0d", i), BUSY, 1'b0);
         if (i < 2) @(negedge CLK);
      end
      RST        = 1'b0;
      DATA_VALID = 1'b0;
      @(negedge CLK);
      check_idle("post_rst", 3);

      // Plain frame, no parity
      send(8'hA5, 1'b0);
      expect_frame("a5", 8'hA5, 1'b0, 1'b0, -1, -1, 1'b0);
      @(negedge CLK);
      check_idle("a5_after", 2);

      // Parity frame, parity bit 1
      PARITY = 1'b1;
      send(8'h01, 1'b1);
      expect_frame("p01", 8'h01, 1'b1, 1'b1, -1, -1, 1'b0);
      @(negedge CLK);
      check_idle("p01_after", 2);

      // Offers during DATA (idx 3) and STOP (idx 9) must be ignored
      send(8'hFF, 1'b0);
      expect_frame("ff", 8'hFF, 1'b0, 1'b0, 3, 9, 1'b0);
      DATA_VALID = 1'b0;
      @(negedge CLK);
      check_idle("ff_after", 3);

      // Back-to-back: DATA_VALID held; second start two cycles after first stop
      send(8'h3C, 1'b0);
      P_DATA = 8'hC3;
      expect_frame("b2b1", 8'h3C, 1'b0, 1'b0, -1, -1, 1'b1);
      @(negedge CLK);
      DATA_VALID = 1'b0;
      expect_frame("b2b2", 8'hC3, 1'b0, 1'b0, -1, -1, 1'b0);
      @(negedge CLK);
      check_idle("b2b_after", 2);

      // Mid-frame reset asserted in frame cycle index 4 (cycle N+5)
      send(8'hA5, 1'b0);
      DATA_VALID = 1'b0;
      check("mr_start", TX_OUT, 1'b0);
      @(negedge CLK);
      check("mr_b0", TX_OUT, 1'b1);
      @(negedge CLK);
      check("mr_b1", TX_OUT, 1'b0);
      @(negedge CLK);
      check("mr_b2", TX_OUT, 1'b1);
      @(negedge CLK);
      check("mr_b3", TX_OUT, 1'b0);
      RST = 1'b1;
      @(negedge CLK);
      check("mr_rst_tx", TX_OUT, 1'b1);
      check("mr_rst_busy", BUSY, 1'b0);
      RST = 1'b0;
      @(negedge CLK);
      check_idle("mr_idle", 2);

      // Fresh parity frame after the abandoned one, parity bit 0
      PARITY = 1'b0;
      send(8'hA5, 1'b1);
      expect_frame("mr_new", 8'hA5, 1'b1, 1'b0, -1, -1, 1'b0);
      @(negedge CLK);
      check_idle("mr_new_after", 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
